// File: rtl/fifo_rd_unpack_pkg.sv
// Shared types and elaboration helpers for the fifo read-side unpacker.
package fifo_rd_unpack_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        EMIT   = 2'd2
    } rd_state_e;

    // Number of output slices carried by one fifo word.
    function automatic int calc_nslice(input int bus_width, input int out_width);
        if (out_width <= 0) return 0;
        return bus_width / out_width;
    endfunction

    // Width of the slice index; never narrower than one bit.
    function automatic int calc_idx_width(input int nslice);
        return (nslice > 1) ? $clog2(nslice) : 1;
    endfunction

    // True when the word splits evenly into 1..16 slices.
    function automatic bit widths_valid(input int bus_width, input int out_width);
        if (out_width <= 0) return 1'b0;
        if ((bus_width % out_width) != 0) return 1'b0;
        if ((bus_width / out_width) < 1) return 1'b0;
        if ((bus_width / out_width) > 16) return 1'b0;
        return 1'b1;
    endfunction

endpackage

// File: rtl/fifo_rd_unpack_if.sv
// Fifo read port plus the sliced valid/ready output stream.
interface fifo_rd_unpack_if #(
    parameter int BUS_WIDTH = 16,
    parameter int OUT_WIDTH = 8
);
    logic                 empty_n;
    logic [BUS_WIDTH-1:0] rd_data;
    logic                 rd;
    logic [OUT_WIDTH-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_last;

    // The unpacker drives the pop and the stream; the environment drives the rest.
    modport master (
        input  empty_n, rd_data, out_ready,
        output rd, out_data, out_valid, out_last
    );

    modport slave (
        output empty_n, rd_data, out_ready,
        input  rd, out_data, out_valid, out_last
    );
endinterface

// File: rtl/fifo_rd_unpack_slicer.sv
// Holds one fifo word and walks through it one OUT_WIDTH slice at a time, LSB first.
module fifo_rd_unpack_slicer
    import fifo_rd_unpack_pkg::*;
#(
    parameter int BUS_WIDTH = 16,
    parameter int OUT_WIDTH = 8
) (
    input  logic                 rd_clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [BUS_WIDTH-1:0] load_data,
    input  logic                 advance,
    output logic [OUT_WIDTH-1:0] slice_data,
    output logic                 slice_last
);
    localparam int NSLICE = calc_nslice(BUS_WIDTH, OUT_WIDTH);
    localparam int IDX_W  = calc_idx_width(NSLICE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    logic [BUS_WIDTH-1:0] hold;
    logic [IDX_W-1:0]     slice_idx;

    // Capture a new word and restart at slice 0, or step to the next slice.
    always_ff @(posedge rd_clk) begin
        if (!rst_n) begin
            hold      <= '0;
            slice_idx <= '0;
        end else if (load) begin
            hold      <= load_data;
            slice_idx <= '0;
        end else if (advance && (slice_idx != LAST_IDX)) begin
            slice_idx <= slice_idx + IDX_W'(1);
        end
    end

    // Select the current slice and flag the final one.
    always_comb begin
        slice_data = hold[int'(slice_idx) * OUT_WIDTH +: OUT_WIDTH];
        slice_last = (slice_idx == LAST_IDX);
    end

endmodule

// File: rtl/fifo_rd_unpack.sv
// Read-side drain engine: pops the 1-word CDC fifo and emits the word as a sliced stream.
module fifo_rd_unpack
    import fifo_rd_unpack_pkg::*;
#(
    parameter int BUS_WIDTH = 16,
    parameter int OUT_WIDTH = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 rd_clk,
    input  logic                 rst_n,
    fifo_rd_unpack_if.master     bus,
    output logic [CNT_WIDTH-1:0] words_rcvd,
    output logic                 busy
);
    if (!widths_valid(BUS_WIDTH, OUT_WIDTH)) begin : g_bad_widths
        $error("fifo_rd_unpack: BUS_WIDTH must be a multiple of OUT_WIDTH giving 1..16 slices");
    end

    rd_state_e            state;
    rd_state_e            state_next;
    logic                 load;
    logic                 advance;
    logic                 rd_q;
    logic [OUT_WIDTH-1:0] slice_data;
    logic                 slice_last;

    // State register.
    always_ff @(posedge rd_clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state; SETTLE only captures if empty_n held for a second cycle.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        advance    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.empty_n) state_next = SETTLE;
            end
            SETTLE: begin
                if (bus.empty_n) begin
                    load       = 1'b1;
                    state_next = EMIT;
                end else begin
                    state_next = IDLE;
                end
            end
            EMIT: begin
                if (bus.out_ready) begin
                    if (slice_last) state_next = IDLE;
                    else            advance    = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // One-cycle pop pulse following the capture, and the popped-word counter.
    always_ff @(posedge rd_clk) begin
        if (!rst_n) begin
            rd_q       <= 1'b0;
            words_rcvd <= '0;
        end else begin
            rd_q <= load;
            if (load) words_rcvd <= words_rcvd + CNT_WIDTH'(1);
        end
    end

    fifo_rd_unpack_slicer #(
        .BUS_WIDTH (BUS_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_slicer (
        .rd_clk     (rd_clk),
        .rst_n      (rst_n),
        .load       (load),
        .load_data  (bus.rd_data),
        .advance    (advance),
        .slice_data (slice_data),
        .slice_last (slice_last)
    );

    // Stream outputs are pure functions of state and the held word.
    always_comb begin
        bus.rd        = rd_q;
        bus.out_valid = (state == EMIT);
        bus.out_last  = (state == EMIT) && slice_last;
        bus.out_data  = slice_data;
        busy          = (state != IDLE);
    end

endmodule
